// File: rtl/menu_pkg.sv
// Shared menu geometry and sprite-ROM layout.
// The game and level screens reuse these defaults.
package menu_pkg;

    localparam int DEF_PIVOT_H    = 150;
    localparam int DEF_DARK_DX    = 2;
    localparam int DEF_PIVOT_V0   = 40;
    localparam int DEF_PITCH_V    = 40;
    localparam int DEF_BTN_W      = 100;
    localparam int DEF_BTN_H      = 30;
    localparam int DEF_LIGHT_BASE = 0;
    localparam int DEF_DARK_BASE  = 3000;
    localparam int DEF_ADDR_W     = 17;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } navDir_e;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Edge detect plus hold-to-repeat for one key level.
// step_o pulses on the press edge, then after REPEAT_DLY cycles and every REPEAT_PER cycles.
module key_repeat #(
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 10000000,
    parameter int CNT_W      = 25
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic key_i,
    output logic step_o
);

    logic             keyPrev_q;
    logic [CNT_W-1:0] repeatCnt_q;
    logic [CNT_W-1:0] repeatCnt_d;
    logic             keyRise;

    assign keyRise = key_i & ~keyPrev_q;

    // A zero count while held means the press began while disabled, so it never repeats.
    always_comb begin
        repeatCnt_d = '0;
        step_o      = 1'b0;
        if (en_i && key_i) begin
            if (keyRise) begin
                step_o      = 1'b1;
                repeatCnt_d = CNT_W'(REPEAT_DLY);
            end else if (repeatCnt_q == CNT_W'(1)) begin
                step_o      = 1'b1;
                repeatCnt_d = CNT_W'(REPEAT_PER);
            end else if (repeatCnt_q != '0) begin
                repeatCnt_d = repeatCnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keyPrev_q   <= 1'b0;
            repeatCnt_q <= '0;
        end else begin
            keyPrev_q   <= key_i;
            repeatCnt_q <= repeatCnt_d;
        end
    end

endmodule

// File: rtl/menu_nav.sv
// Start-screen menu: keyboard cursor with auto-repeat, valid/ready selection,
// and a registered sprite-ROM address per VGA pixel.
module menu_nav
    import menu_pkg::*;
#(
    parameter int NUM_ITEMS  = 5,
    parameter int IDX_W      = 3,
    parameter int INIT_IDX   = 0,
    parameter int WRAP       = 1,
    parameter int PIVOT_H    = DEF_PIVOT_H,
    parameter int DARK_DX    = DEF_DARK_DX,
    parameter int PIVOT_V0   = DEF_PIVOT_V0,
    parameter int PITCH_V    = DEF_PITCH_V,
    parameter int BTN_W      = DEF_BTN_W,
    parameter int BTN_H      = DEF_BTN_H,
    parameter int LIGHT_BASE = DEF_LIGHT_BASE,
    parameter int DARK_BASE  = DEF_DARK_BASE,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              key_up_i,
    input  logic              key_down_i,
    input  logic              key_sel_i,
    input  logic [9:0]        vga_h_i,
    input  logic [9:0]        vga_v_i,
    input  logic              sel_ready_i,
    output logic              sel_valid_o,
    output logic [IDX_W-1:0]  sel_idx_o,
    output logic [IDX_W-1:0]  cursor_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              pix_en_o
);

    localparam int CNT_W = $clog2(maxInt(REPEAT_DLY, REPEAT_PER) + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ITEMS - 1);
    localparam logic [ADDR_W-1:0] LIGHT_L  = ADDR_W'(PIVOT_H);
    localparam logic [ADDR_W-1:0] DARK_L   = ADDR_W'(PIVOT_H - DARK_DX);
    localparam logic [ADDR_W-1:0] BTN_W_A  = ADDR_W'(BTN_W);
    localparam logic [ADDR_W-1:0] BTN_H_A  = ADDR_W'(BTN_H);
    localparam logic [ADDR_W-1:0] PITCH_A  = ADDR_W'(PITCH_V);
    localparam logic [ADDR_W-1:0] V0_A     = ADDR_W'(PIVOT_V0);
    localparam logic [ADDR_W-1:0] LBASE_A  = ADDR_W'(LIGHT_BASE);
    localparam logic [ADDR_W-1:0] DBASE_A  = ADDR_W'(DARK_BASE);

    logic [IDX_W-1:0]  cursor_q, cursor_d;
    logic              selValid_q;
    logic [IDX_W-1:0]  selIdx_q;
    logic              selPrev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pixEn_q, pixEn_d;

    logic    navEn, upActive, downActive, stepUp, stepDown;
    logic    selStart;
    navDir_e navDir;

    // Both keys held cancels out, so neither repeater sees an active key.
    assign upActive   = key_up_i & ~key_down_i;
    assign downActive = key_down_i & ~key_up_i;
    assign navEn      = en_i & ~selValid_q;
    assign selStart   = navEn & key_sel_i & ~selPrev_q;

    key_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER),
        .CNT_W      (CNT_W)
    ) u_repeat_up (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (navEn),
        .key_i  (upActive),
        .step_o (stepUp)
    );

    key_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER),
        .CNT_W      (CNT_W)
    ) u_repeat_down (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (navEn),
        .key_i  (downActive),
        .step_o (stepDown)
    );

    assign navDir = stepUp ? DIR_UP : (stepDown ? DIR_DOWN : DIR_NONE);

    always_comb begin
        cursor_d = cursor_q;
        if (!selStart) begin
            case (navDir)
                DIR_UP: begin
                    if (cursor_q == '0) cursor_d = (WRAP != 0) ? LAST_IDX : '0;
                    else                cursor_d = cursor_q - IDX_W'(1);
                end
                DIR_DOWN: begin
                    if (cursor_q == LAST_IDX) cursor_d = (WRAP != 0) ? '0 : LAST_IDX;
                    else                      cursor_d = cursor_q + IDX_W'(1);
                end
                default: cursor_d = cursor_q;
            endcase
        end
    end

    logic [9:0]        hPix, vPix;
    logic [ADDR_W-1:0] hA, vA, rowTop;

    assign hPix = vga_h_i >> 1;
    assign vPix = vga_v_i >> 1;
    assign hA   = ADDR_W'(hPix);
    assign vA   = ADDR_W'(vPix);

    // Rows never overlap vertically, so at most one row can claim a pixel.
    always_comb begin
        pixEn_d = 1'b0;
        addr_d  = '0;
        rowTop  = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            rowTop = V0_A + ADDR_W'(i) * PITCH_A;
            if (!pixEn_d && vA >= rowTop && vA < rowTop + BTN_H_A) begin
                if (IDX_W'(i) == cursor_q) begin
                    if (hA >= DARK_L && hA < DARK_L + BTN_W_A) begin
                        pixEn_d = 1'b1;
                        addr_d  = DBASE_A + (vA - rowTop) * BTN_W_A + (hA - DARK_L);
                    end
                end else if (hA >= LIGHT_L && hA < LIGHT_L + BTN_W_A) begin
                    pixEn_d = 1'b1;
                    addr_d  = LBASE_A + (vA - rowTop) * BTN_W_A + (hA - LIGHT_L);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cursor_q   <= IDX_W'(INIT_IDX);
            selValid_q <= 1'b0;
            selIdx_q   <= '0;
            selPrev_q  <= 1'b0;
            addr_q     <= '0;
            pixEn_q    <= 1'b0;
        end else begin
            cursor_q  <= cursor_d;
            selPrev_q <= key_sel_i;
            addr_q    <= addr_d;
            pixEn_q   <= pixEn_d;
            if (selStart) begin
                selValid_q <= 1'b1;
                selIdx_q   <= cursor_q;
            end else if (selValid_q && sel_ready_i) begin
                selValid_q <= 1'b0;
            end
        end
    end

    assign sel_valid_o = selValid_q;
    assign sel_idx_o   = selIdx_q;
    assign cursor_o    = cursor_q;
    assign addr_o      = addr_q;
    assign pix_en_o    = pixEn_q;

endmodule

// File: tb/tb_menu_nav.sv
// Directed bench for menu_nav with short repeat timings (delay 10, period 4).
module tb_menu_nav;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, keyUp, keyDown, keySel, selReady;
    logic [9:0]  vgaH, vgaV;
    logic        selValid, pixEn;
    logic [2:0]  selIdx, cursor;
    logic [16:0] addr;

    int assertCount = 0;
    int failCount   = 0;
    logic [31:0] expCur;

    always #5 clk = ~clk;

    menu_nav #(
        .NUM_ITEMS  (5),
        .IDX_W      (3),
        .INIT_IDX   (0),
        .WRAP       (1),
        .REPEAT_DLY (10),
        .REPEAT_PER (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .key_up_i    (keyUp),
        .key_down_i  (keyDown),
        .key_sel_i   (keySel),
        .vga_h_i     (vgaH),
        .vga_v_i     (vgaV),
        .sel_ready_i (selReady),
        .sel_valid_o (selValid),
        .sel_idx_o   (selIdx),
        .cursor_o    (cursor),
        .addr_o      (addr),
        .pix_en_o    (pixEn)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle press of up (dir=0) or down (dir=1), then a released cycle.
    task automatic applyStimulus(input bit dir);
        if (dir) keyDown = 1'b1; else keyUp = 1'b1;
        tick();
        keyUp   = 1'b0;
        keyDown = 1'b0;
        tick();
    endtask

    task automatic setVga(input int h, input int v);
        vgaH = 10'(h);
        vgaV = 10'(v);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; keyUp = 1'b0; keyDown = 1'b0; keySel = 1'b0;
        selReady = 1'b0; vgaH = '0; vgaV = '0;
        #3;
        checkOutput("rst_cursor", 32'(cursor), 0);
        checkOutput("rst_valid", 32'(selValid), 0);
        checkOutput("rst_pix", 32'(pixEn), 0);
        checkOutput("rst_addr", 32'(addr), 0);
        #9;
        rst_n = 1'b1;
        tick();

        // Dark button for cursor row 0 starts at h=148
        setVga(300, 80); tick();
        checkOutput("pix_dark_h150", 32'(pixEn), 1);
        checkOutput("addr_dark_h150", 32'(addr), 3002);
        setVga(296, 80); tick();
        checkOutput("addr_dark_h148", 32'(addr), 3000);

        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1);
            checkOutput("down_pulse", 32'(cursor), 32'(i % 5));
        end
        applyStimulus(1'b0);
        checkOutput("up_wrap", 32'(cursor), 4);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("up_to_2", 32'(cursor), 2);

        // Held up key: steps on cycles 1, 11, 15, 19
        expCur = 2;
        keyUp = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1 || c == 11 || c == 15 || c == 19)
                expCur = (expCur == 0) ? 32'd4 : expCur - 32'd1;
            checkOutput("hold_up", 32'(cursor), expCur);
        end
        keyUp = 1'b0; tick();

        keyUp = 1'b1; keyDown = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        checkOutput("both_held", 32'(cursor), 3);
        keyDown = 1'b0; tick();
        checkOutput("both_to_up", 32'(cursor), 2);
        keyUp = 1'b0; keyDown = 1'b1; tick();
        checkOutput("dir_change", 32'(cursor), 3);
        keyDown = 1'b0; tick();

        keySel = 1'b1; tick();
        keySel = 1'b0;
        checkOutput("sel_valid_set", 32'(selValid), 1);
        checkOutput("sel_idx_set", 32'(selIdx), 3);
        for (int i = 0; i < 5; i++) begin
            keyDown = (i % 2 == 0);
            tick();
            checkOutput("sel_hold_valid", 32'(selValid), 1);
            checkOutput("sel_hold_idx", 32'(selIdx), 3);
            checkOutput("sel_hold_cursor", 32'(cursor), 3);
        end
        keyDown = 1'b0; selReady = 1'b1; tick();
        checkOutput("sel_ready_clear", 32'(selValid), 0);
        checkOutput("sel_ready_cursor", 32'(cursor), 3);
        selReady = 1'b0; tick();

        en = 1'b0;
        applyStimulus(1'b1);
        checkOutput("en0_nav", 32'(cursor), 3);
        keySel = 1'b1; tick(); keySel = 1'b0;
        checkOutput("en0_sel", 32'(selValid), 0);
        keyDown = 1'b1; tick();
        en = 1'b1; tick(); tick(); tick();
        checkOutput("held_at_en", 32'(cursor), 3);
        keyDown = 1'b0; tick();
        keyDown = 1'b1; tick();
        checkOutput("repress_after_en", 32'(cursor), 4);
        keyDown = 1'b0; tick();

        keySel = 1'b1; keyDown = 1'b1; tick();
        keySel = 1'b0; keyDown = 1'b0;
        checkOutput("sel_wins_valid", 32'(selValid), 1);
        checkOutput("sel_wins_idx", 32'(selIdx), 4);
        checkOutput("sel_wins_cursor", 32'(cursor), 4);
        selReady = 1'b1; tick(); selReady = 1'b0;
        checkOutput("sel_wins_clear", 32'(selValid), 0);

        applyStimulus(1'b1);
        checkOutput("wrap_to_0", 32'(cursor), 0);
        setVga(400, 160); tick();
        checkOutput("pix_light_row1", 32'(pixEn), 1);
        checkOutput("addr_light_row1", 32'(addr), 50);
        setVga(298, 140); tick();
        checkOutput("pix_gap", 32'(pixEn), 0);
        checkOutput("addr_gap", 32'(addr), 0);
        setVga(296, 138); tick();
        checkOutput("addr_dark_last", 32'(addr), 5900);
        setVga(498, 80); tick();
        checkOutput("pix_dark_right", 32'(pixEn), 0);
        setVga(296, 160); tick();
        checkOutput("pix_light_left", 32'(pixEn), 0);

        // Reset mid-hold and mid-handshake
        setVga(300, 80);
        keyUp = 1'b1; tick(); tick();
        keySel = 1'b1; tick(); keySel = 1'b0; tick();
        checkOutput("pre_rst_valid", 32'(selValid), 1);
        checkOutput("pre_rst_cursor", 32'(cursor), 4);
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_cursor", 32'(cursor), 0);
        checkOutput("mid_rst_valid", 32'(selValid), 0);
        checkOutput("mid_rst_idx", 32'(selIdx), 0);
        checkOutput("mid_rst_pix", 32'(pixEn), 0);
        keyUp = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        checkOutput("post_rst_cursor", 32'(cursor), 0);
        applyStimulus(1'b1);
        checkOutput("post_rst_step", 32'(cursor), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
